// File: rtl/iq_deserializer_if.sv
// ---------------------------------------------------------------------------
// iq_deserializer_if
// Bundles the byte-FIFO read side and the paired I/Q FIFO write side of the
// I/Q deserializer.
//   data_in    : head byte of the input FIFO, valid while in_empty==0
//   in_empty   : input FIFO empty
//   in_rd_en   : input FIFO pop
//   i_out_full : I output FIFO full
//   q_out_full : Q output FIFO full
//   out_wr_en  : push into both output FIFOs
//   i_out/q_out: quantized I/Q samples
//   resync     : byte-alignment restart; present only with IQ_DESER_RESYNC_EN
// Modports: master = FIFO environment, slave = deserializer.
// ---------------------------------------------------------------------------
interface iq_deserializer_if #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
);
  logic [BYTE_SIZE-1:0] data_in;
  logic                 in_empty;
  logic                 in_rd_en;
  logic                 i_out_full;
  logic                 q_out_full;
  logic                 out_wr_en;
  logic [DATA_SIZE-1:0] i_out;
  logic [DATA_SIZE-1:0] q_out;
`ifdef IQ_DESER_RESYNC_EN
  logic                 resync;

  modport master (
    output data_in, in_empty, i_out_full, q_out_full, resync,
    input  in_rd_en, out_wr_en, i_out, q_out
  );
  modport slave (
    input  data_in, in_empty, i_out_full, q_out_full, resync,
    output in_rd_en, out_wr_en, i_out, q_out
  );
`else
  modport master (
    output data_in, in_empty, i_out_full, q_out_full,
    input  in_rd_en, out_wr_en, i_out, q_out
  );
  modport slave (
    input  data_in, in_empty, i_out_full, q_out_full,
    output in_rd_en, out_wr_en, i_out, q_out
  );
`endif
endinterface

// File: rtl/iq_deserializer.sv
// ---------------------------------------------------------------------------
// iq_deserializer
// Pops interleaved I/Q bytes from the input byte FIFO, assembles one I and one
// Q sample of SAMPLE_BYTES bytes each, sign-extends them to DATA_SIZE, shifts
// them left by BITS and pushes the pair into the I and Q output FIFOs together.
// A one-pair pending register lets byte collection run ahead while the
// outputs are back-pressured; collection only stalls at the last byte of the
// next pair.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : iq_deserializer_if.slave (input FIFO pop side, output push side)
// Optional feature macro: IQ_DESER_RESYNC_EN adds bus.resync, which restarts
// byte alignment at index 0 without touching a pending pair.
// ---------------------------------------------------------------------------
module iq_deserializer #(
  parameter int DATA_SIZE    = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int SAMPLE_BYTES = 2,
  parameter int BITS         = 10,
  parameter int BIG_ENDIAN   = 0
) (
  input logic              clock,
  input logic              reset,
  iq_deserializer_if.slave bus
);
  localparam int          SW         = SAMPLE_BYTES * BYTE_SIZE;
  localparam int          PAIR_BYTES = 2 * SAMPLE_BYTES;
  localparam logic [2:0]  LAST       = 3'(PAIR_BYTES - 1);
  localparam logic [2:0]  Q_FIRST    = 3'(SAMPLE_BYTES);

  if ((SAMPLE_BYTES < 1) || (SAMPLE_BYTES > 4) || (SW > DATA_SIZE)) begin : g_bad_cfg
    $error("iq_deserializer: SAMPLE_BYTES must be 1..4 and SAMPLE_BYTES*BYTE_SIZE <= DATA_SIZE");
  end
  if (($bits(bus.i_out) != DATA_SIZE) || ($bits(bus.data_in) != BYTE_SIZE)) begin : g_bad_if
    $error("iq_deserializer: interface widths do not match module parameters");
  end

  // Writes byte b into sample lane pos, honouring the configured byte order.
  function automatic logic [SW-1:0] place_byte(input logic [SW-1:0]        part,
                                               input logic [BYTE_SIZE-1:0] b,
                                               input logic [2:0]           pos);
    logic [SW-1:0] res;
    int            lane;
    res = part;
    if (BIG_ENDIAN != 0) begin
      lane = SAMPLE_BYTES - 1 - int'(pos);
    end else begin
      lane = int'(pos);
    end
    for (int k = 0; k < SAMPLE_BYTES; k++) begin
      if (lane == k) begin
        res[k*BYTE_SIZE +: BYTE_SIZE] = b;
      end else begin
        res[k*BYTE_SIZE +: BYTE_SIZE] = res[k*BYTE_SIZE +: BYTE_SIZE];
      end
    end
    return res;
  endfunction

  // Sign-extends an assembled sample to DATA_SIZE and applies the quantization shift.
  function automatic logic [DATA_SIZE-1:0] quantize(input logic [SW-1:0] s);
    logic [DATA_SIZE-1:0] ext;
    ext = DATA_SIZE'($signed(s));
    return ext << BITS;
  endfunction

  logic [2:0]           r_byte_idx;
  logic [SW-1:0]        r_i_part;
  logic [SW-1:0]        r_q_part;
  logic                 r_pend_valid;
  logic [DATA_SIZE-1:0] r_i_out;
  logic [DATA_SIZE-1:0] r_q_out;

  logic                 w_resync;
  logic                 w_at_last;
  logic                 w_is_q;
  logic [2:0]           w_pos;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_commit;
  logic [SW-1:0]        w_i_next;
  logic [SW-1:0]        w_q_next;

`ifdef IQ_DESER_RESYNC_EN
  assign w_resync = bus.resync;
`else
  assign w_resync = 1'b0;
`endif

  assign w_at_last = (r_byte_idx == LAST);
  assign w_is_q    = (r_byte_idx >= Q_FIRST);
  assign w_pos     = w_is_q ? (r_byte_idx - Q_FIRST) : r_byte_idx;

  // Push whenever a pair is pending and both outputs have room; pop unless the
  // last byte would need a pending slot that is neither free nor freeing now.
  assign w_wr_en  = r_pend_valid && !bus.i_out_full && !bus.q_out_full && !reset;
  assign w_rd_en  = !bus.in_empty && !(w_at_last && r_pend_valid && !w_wr_en)
                    && !w_resync && !reset;
  assign w_commit = w_rd_en && w_at_last;

  assign bus.in_rd_en  = w_rd_en;
  assign bus.out_wr_en = w_wr_en;
  assign bus.i_out     = r_i_out;
  assign bus.q_out     = r_q_out;

  // Next partial-sample contents including the byte being popped this cycle.
  always_comb begin
    w_i_next = r_i_part;
    w_q_next = r_q_part;
    if (w_rd_en) begin
      if (w_is_q) begin
        w_q_next = place_byte(r_q_part, bus.data_in, w_pos);
      end else begin
        w_i_next = place_byte(r_i_part, bus.data_in, w_pos);
      end
    end else begin
      w_i_next = r_i_part;
      w_q_next = r_q_part;
    end
  end

  // Byte index and partial-sample collection registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_byte_idx <= 3'd0;
      r_i_part   <= '0;
      r_q_part   <= '0;
    end else if (w_resync) begin
      r_byte_idx <= 3'd0;
      r_i_part   <= '0;
      r_q_part   <= '0;
    end else if (w_commit) begin
      // The completed pair moves to the pending registers; start afresh.
      r_byte_idx <= 3'd0;
      r_i_part   <= '0;
      r_q_part   <= '0;
    end else if (w_rd_en) begin
      r_byte_idx <= r_byte_idx + 3'd1;
      r_i_part   <= w_i_next;
      r_q_part   <= w_q_next;
    end else begin
      r_byte_idx <= r_byte_idx;
      r_i_part   <= r_i_part;
      r_q_part   <= r_q_part;
    end
  end

  // Pending pair: a commit overwrites it (even while it is being pushed),
  // a push without commit just frees it and leaves the outputs unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_i_out      <= '0;
      r_q_out      <= '0;
    end else if (w_commit) begin
      r_pend_valid <= 1'b1;
      r_i_out      <= quantize(w_i_next);
      r_q_out      <= quantize(w_q_next);
    end else if (w_wr_en) begin
      r_pend_valid <= 1'b0;
      r_i_out      <= r_i_out;
      r_q_out      <= r_q_out;
    end else begin
      r_pend_valid <= r_pend_valid;
      r_i_out      <= r_i_out;
      r_q_out      <= r_q_out;
    end
  end
endmodule

// File: tb/tb_iq_deserializer.sv
// ---------------------------------------------------------------------------
// tb_iq_deserializer
// Drives a little-endian and a big-endian instance (SAMPLE_BYTES=2, BITS=10)
// with identical stimulus: a fixed vector table, a reset-mid-pair sequence,
// an optional resync sequence and a randomized run against a queue-based
// reference model.
// ---------------------------------------------------------------------------
module tb_iq_deserializer;
  localparam int DS   = 32;
  localparam int BS   = 8;
  localparam int SB   = 2;
  localparam int QB   = 10;
  localparam int NRND = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tb_data;
  logic       tb_empty;
  logic       tb_ifull;
  logic       tb_qfull;

  always #5 clock = ~clock;

  iq_deserializer_if #(.DATA_SIZE(DS), .BYTE_SIZE(BS)) if_le ();
  iq_deserializer_if #(.DATA_SIZE(DS), .BYTE_SIZE(BS)) if_be ();

  assign if_le.data_in    = tb_data;
  assign if_le.in_empty   = tb_empty;
  assign if_le.i_out_full = tb_ifull;
  assign if_le.q_out_full = tb_qfull;
  assign if_be.data_in    = tb_data;
  assign if_be.in_empty   = tb_empty;
  assign if_be.i_out_full = tb_ifull;
  assign if_be.q_out_full = tb_qfull;
`ifdef IQ_DESER_RESYNC_EN
  logic tb_resync;
  assign if_le.resync = tb_resync;
  assign if_be.resync = tb_resync;
`endif

  iq_deserializer #(.DATA_SIZE(DS), .BYTE_SIZE(BS), .SAMPLE_BYTES(SB), .BITS(QB), .BIG_ENDIAN(0))
    u_le (.clock(clock), .reset(reset), .bus(if_le));
  iq_deserializer #(.DATA_SIZE(DS), .BYTE_SIZE(BS), .SAMPLE_BYTES(SB), .BITS(QB), .BIG_ENDIAN(1))
    u_be (.clock(clock), .reset(reset), .bus(if_be));

  typedef struct {
    logic        empty, ifull, qfull;
    logic [7:0]  data;
    logic        rd, wr;
    logic [31:0] ile, qle, ibe, qbe;
  } vec_t;

  typedef struct {
    logic [31:0] ile, qle, ibe, qbe;
  } pair_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic erd, input logic ewr);
    chk1({tag, "_rd_le"}, if_le.in_rd_en, erd);
    chk1({tag, "_wr_le"}, if_le.out_wr_en, ewr);
    chk1({tag, "_rd_be"}, if_be.in_rd_en, erd);
    chk1({tag, "_wr_be"}, if_be.out_wr_en, ewr);
  endtask

  task automatic check_out(input string tag, input pair_t p);
    chk({tag, "_i_le"}, if_le.i_out, p.ile);
    chk({tag, "_q_le"}, if_le.q_out, p.qle);
    chk({tag, "_i_be"}, if_be.i_out, p.ibe);
    chk({tag, "_q_be"}, if_be.q_out, p.qbe);
  endtask

  // Apply inputs on the falling edge and let combinational outputs settle.
  task automatic drive(input logic e, input logic fi, input logic fq, input logic [7:0] d);
    @(negedge clock);
    tb_empty = e;
    tb_ifull = fi;
    tb_qfull = fq;
    tb_data  = d;
    #1;
  endtask

  // Hold reset for a cycle with a non-empty FIFO; pops and pushes must stay low.
  task automatic do_reset(input string tag);
    pair_t z;
    z = '{32'h0, 32'h0, 32'h0, 32'h0};
    @(negedge clock);
    reset    = 1'b1;
    tb_empty = 1'b0;
    tb_ifull = 1'b0;
    tb_qfull = 1'b0;
    tb_data  = 8'h5A;
    #1;
    check_ctrl({tag, "_in_rst"}, 1'b0, 1'b0);
    check_out({tag, "_in_rst"}, z);
    @(negedge clock);
    tb_empty = 1'b1;
    reset    = 1'b0;
    #1;
  endtask

  // Two's-complement sample value times 2^BITS, truncated to 32 bits.
  function automatic logic [31:0] quant(input logic [7:0] first, input logic [7:0] second,
                                        input bit be);
    int s;
    if (be) s = int'(first) * 256 + int'(second);
    else    s = int'(second) * 256 + int'(first);
    if (s >= 32768) s = s - 65536;
    return 32'(s * 1024);
  endfunction

  function automatic pair_t make_pair(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2, input logic [7:0] b3);
    pair_t p;
    p.ile = quant(b0, b1, 1'b0);
    p.qle = quant(b2, b3, 1'b0);
    p.ibe = quant(b0, b1, 1'b1);
    p.qbe = quant(b2, b3, 1'b1);
    return p;
  endfunction

  function automatic vec_t row(input logic e, input logic fi, input logic fq, input logic [7:0] d,
                               input logic rd, input logic wr, input pair_t p);
    vec_t v;
    v.empty = e;  v.ifull = fi; v.qfull = fq; v.data = d;
    v.rd    = rd; v.wr    = wr;
    v.ile   = p.ile; v.qle = p.qle; v.ibe = p.ibe; v.qbe = p.qbe;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[17];
    pair_t z, p1, pa, pb, pr, exp_p;
    pair_t sb[$];
    logic [7:0] cur[4];
    int nbytes, fed, pushes;
    logic e, fi, fq, erd, ewr;
    logic [7:0] d;

    z  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    p1 = '{32'h0048_D000, 32'hFEAF_3400, 32'h00D0_4800, 32'hFF36_AC00};
    pa = '{32'h0008_0400, 32'h0010_0C00, 32'h0004_0800, 32'h000C_1000};
    pb = '{32'h0018_1400, 32'h0020_1C00, 32'h0014_1800, 32'h001C_2000};
    pr = '{32'h0000_0400, 32'hFFFF_FC00, 32'h0004_0000, 32'hFFFF_FC00};

    // Pair 34 12 CD AB with free outputs, then two pairs against a full I FIFO.
    tbl[0]  = row(1'b0, 1'b0, 1'b0, 8'h34, 1'b1, 1'b0, z);
    tbl[1]  = row(1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, z);
    tbl[2]  = row(1'b0, 1'b0, 1'b0, 8'hCD, 1'b1, 1'b0, z);
    tbl[3]  = row(1'b0, 1'b0, 1'b0, 8'hAB, 1'b1, 1'b0, z);
    tbl[4]  = row(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, p1);
    tbl[5]  = row(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, p1);
    tbl[6]  = row(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, p1);
    tbl[7]  = row(1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, p1);
    tbl[8]  = row(1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, p1);
    tbl[9]  = row(1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 1'b0, p1);
    tbl[10] = row(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, pa);
    tbl[11] = row(1'b0, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0, pa);
    tbl[12] = row(1'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0, pa);
    tbl[13] = row(1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, pa);
    tbl[14] = row(1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, pa);
    tbl[15] = row(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, pb);
    tbl[16] = row(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, pb);

    reset    = 1'b1;
    tb_empty = 1'b1;
    tb_ifull = 1'b0;
    tb_qfull = 1'b0;
    tb_data  = 8'h00;
`ifdef IQ_DESER_RESYNC_EN
    tb_resync = 1'b0;
`endif
    do_reset("init");

    for (int i = 0; i < 17; i++) begin
      pair_t ep;
      drive(tbl[i].empty, tbl[i].ifull, tbl[i].qfull, tbl[i].data);
      ep = '{tbl[i].ile, tbl[i].qle, tbl[i].ibe, tbl[i].qbe};
      check_ctrl($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr);
      check_out($sformatf("vec%0d", i), ep);
    end

    // Reset after three bytes of a pair: nothing may be pushed afterwards.
    drive(1'b0, 1'b0, 1'b0, 8'hAA); check_ctrl("mid_b0", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hBB); check_ctrl("mid_b1", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hCC); check_ctrl("mid_b2", 1'b1, 1'b0);
    do_reset("mid");
    drive(1'b1, 1'b0, 1'b0, 8'h00); check_ctrl("mid_idle", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h01); check_ctrl("mid_n0", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00); check_ctrl("mid_n1", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hFF); check_ctrl("mid_n2", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hFF); check_ctrl("mid_n3", 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00); check_ctrl("mid_push", 1'b0, 1'b1);
    check_out("mid_push", pr);
    drive(1'b1, 1'b0, 1'b0, 8'h00); check_ctrl("mid_after", 1'b0, 1'b0);

`ifdef IQ_DESER_RESYNC_EN
    // A stray byte followed by resync must not disturb the next pair.
    drive(1'b0, 1'b0, 1'b0, 8'h77); check_ctrl("rs_stray", 1'b1, 1'b0);
    @(negedge clock);
    tb_resync = 1'b1;
    tb_data   = 8'h34;
    #1;
    check_ctrl("rs_pulse", 1'b0, 1'b0);
    @(negedge clock);
    tb_resync = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h34); check_ctrl("rs_b0", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h12); check_ctrl("rs_b1", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hCD); check_ctrl("rs_b2", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'hAB); check_ctrl("rs_b3", 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00); check_ctrl("rs_push", 1'b0, 1'b1);
    check_out("rs_push", p1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
`endif

    // Randomized run: FIFO gaps and full flags against the reference model.
    do_reset("rnd");
    nbytes = 0;
    fed    = 0;
    pushes = 0;
    for (int cyc = 0; cyc < 5000 && pushes < NRND; cyc++) begin
      e  = (fed >= 4 * NRND) ? 1'b1 : ($urandom_range(0, 9) < 3);
      fi = ($urandom_range(0, 9) < 3);
      fq = ($urandom_range(0, 9) < 3);
      d  = 8'($urandom);
      drive(e, fi, fq, d);
      ewr = (sb.size() != 0) && !fi && !fq;
      erd = !e && !((nbytes == 2 * SB - 1) && (sb.size() != 0) && !ewr);
      check_ctrl("rnd", erd, ewr);
      if (ewr) begin
        exp_p = sb.pop_front();
        check_out($sformatf("rnd_pair%0d", pushes), exp_p);
        pushes++;
      end
      if (erd) begin
        cur[nbytes] = d;
        fed++;
        if (nbytes == 2 * SB - 1) begin
          sb.push_back(make_pair(cur[0], cur[1], cur[2], cur[3]));
          nbytes = 0;
        end else begin
          nbytes++;
        end
      end
    end
    chk("rnd_push_count", 32'(pushes), 32'(NRND));
    chk("rnd_bytes_fed", 32'(fed), 32'(4 * NRND));
    chk("rnd_left_pending", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
